// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx.
// Signals:
//   rx_in           raw asynchronous serial line, idles high
//   data_out[7:0]   last successfully received byte
//   valid_out       one-cycle pulse, data_out is new
//   framing_err_out one-cycle pulse, stop bit sampled low
//   parity_err_out  one-cycle pulse, parity mismatch (0 without parity)
// Modports: master = the receiver itself, slave = line driver / byte consumer.
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       framing_err_out;
  logic       parity_err_out;

  modport master (
    input  rx_in,
    output data_out,
    output valid_out,
    output framing_err_out,
    output parity_err_out
  );

  modport slave (
    output rx_in,
    input  data_out,
    input  valid_out,
    input  framing_err_out,
    input  parity_err_out
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling (8E1 when UART_RX_PARITY_EN
// is defined). Good bytes leave as a one-cycle valid_out pulse with data_out;
// malformed frames raise a one-cycle error pulse and are dropped.
// Ports:
//   clk_in    system clock, rising edge
//   rst_n_in  asynchronous active-low reset
//   bus       uart_rx_if.master: rx_in in; data_out, valid_out,
//             framing_err_out, parity_err_out out (all registered)
// Parameter: CLKS_PER_BAUD clock cycles per bit, even, >= 4.
// Macro: UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned CLKS_PER_BAUD = 868
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  uart_rx_if.master   bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BAUD);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BAUD - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  logic             r_done;
  logic             r_stop_bit;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bit;
  logic             r_perr;
  logic             w_par_bad;
`endif

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= bus.rx_in;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: XOR over data and parity bit must be 0.
  assign w_par_bad = ^{r_shift, r_par_bit};
`endif

  // Frame FSM; the stop sample is registered in r_done/r_stop_bit and turned
  // into an output pulse one cycle later, so the FSM is already back in IDLE
  // and can catch a start bit immediately following the stop bit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_stop_bit <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif

      // Output stage: framing error wins over parity error; both drop the byte.
      if (r_done) begin
        if (!r_stop_bit) begin
          r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if (w_par_bad) begin
          r_perr <= 1'b1;
`endif
        end else begin
          r_valid <= 1'b1;
          r_data  <= r_shift;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_rx_prev && !r_sync2) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_sync2 ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_par_bit <= r_sync2;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt      <= '0;
            r_done     <= 1'b1;
            r_stop_bit <= r_sync2;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out        = r_data;
  assign bus.valid_out       = r_valid;
  assign bus.framing_err_out = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err_out  = r_perr;
`else
  assign bus.parity_err_out  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BAUD = 16. A frame-level model turns every
// transmitted frame into one expected output event at a computed cycle; a
// per-cycle compare process checks all outputs against it. Literal checks
// pin latency, spacing and received bytes.
module tb_uart_rx;

  localparam int unsigned C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT     = 2 + C / 2 + 9 * C + 1 + C;
  localparam int unsigned LAT_LIT = 171;
  localparam int unsigned GAP_LIT = 176;
`else
  localparam int unsigned LAT     = 2 + C / 2 + 9 * C + 1;
  localparam int unsigned LAT_LIT = 155;
  localparam int unsigned GAP_LIT = 160;
`endif

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  kind;
    logic [7:0]  data;
  } ev_t;

  logic clk_in;
  logic rst_n_in;
  uart_rx_if bus_if ();

  uart_rx #(.CLKS_PER_BAUD(C)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus_if)
  );

  int          checks;
  int          errors;
  int unsigned cyc;
  ev_t         q[$];
  ev_t         ev;
  logic [7:0]  model_data;
  int unsigned valid_cyc[$];
  logic [7:0]  valid_dat[$];
  int unsigned ferr_cnt;
  int unsigned perr_cnt;
  logic        e_v, e_f, e_p;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_in) begin
    e_v = 1'b0;
    e_f = 1'b0;
    e_p = 1'b0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      ev = q.pop_front();
      case (ev.kind)
        K_VALID: begin e_v = 1'b1; model_data = ev.data; end
        K_FERR:  e_f = 1'b1;
        default: e_p = 1'b1;
      endcase
    end
    chk("outputs{v,fe,pe,data}",
        32'({bus_if.valid_out, bus_if.framing_err_out, bus_if.parity_err_out, bus_if.data_out}),
        32'({e_v, e_f, e_p, model_data}));
    if (bus_if.valid_out === 1'b1) begin
      valid_cyc.push_back(cyc);
      valid_dat.push_back(bus_if.data_out);
    end
    if (bus_if.framing_err_out === 1'b1) ferr_cnt++;
    if (bus_if.parity_err_out === 1'b1) perr_cnt++;
  end

  task automatic hold(input logic b, input int unsigned n);
    bus_if.rx_in = b;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Sends one frame and registers the outcome the receiver must report.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    ev_t e;
    logic pbit;
    pbit  = (^d) ^ par_flip;
    e.cyc = cyc + 1 + LAT;
    e.data = d;
    if (!stop) e.kind = K_FERR;
`ifdef UART_RX_PARITY_EN
    else if ((^d) ^ pbit) e.kind = K_PERR;
`endif
    else e.kind = K_VALID;
    q.push_back(e);
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(d[i], C);
`ifdef UART_RX_PARITY_EN
    hold(pbit, C);
`else
    if (pbit === 1'bx) $display("parity bit unknown");
`endif
    hold(stop, C);
  endtask

  task automatic clear_logs();
    valid_cyc.delete();
    valid_dat.delete();
    ferr_cnt = 0;
    perr_cnt = 0;
  endtask

  initial begin
    int unsigned t0;
    checks = 0;
    errors = 0;
    cyc = 0;
    model_data = 8'h00;
    ferr_cnt = 0;
    perr_cnt = 0;
    rst_n_in = 1'b0;
    bus_if.rx_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_data", 32'(bus_if.data_out), 32'h0);
    chk("reset_pulses", 32'({bus_if.valid_out, bus_if.framing_err_out, bus_if.parity_err_out}), 32'h0);
    rst_n_in = 1'b1;
    hold(1'b1, 10);

    // Single byte with exact latency.
    clear_logs();
    t0 = cyc;
    send_frame(8'h57, 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("single_count", 32'(valid_cyc.size()), 32'd1);
    if (valid_cyc.size() == 1) begin
      chk("single_latency", 32'(valid_cyc[0] - (t0 + 1)), 32'(LAT_LIT));
      chk("single_data", 32'(valid_dat[0]), 32'h57);
    end
    chk("single_no_err", 32'(ferr_cnt + perr_cnt), 32'd0);

    // Back-to-back with no idle time.
    clear_logs();
    send_frame(8'h52, 1'b1, 1'b0);
    send_frame(8'h48, 1'b1, 1'b0);
    send_frame(8'h53, 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("b2b_count", 32'(valid_cyc.size()), 32'd3);
    if (valid_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(valid_cyc[1] - valid_cyc[0]), 32'(GAP_LIT));
      chk("b2b_gap2", 32'(valid_cyc[2] - valid_cyc[1]), 32'(GAP_LIT));
      chk("b2b_d0", 32'(valid_dat[0]), 32'h52);
      chk("b2b_d1", 32'(valid_dat[1]), 32'h48);
      chk("b2b_d2", 32'(valid_dat[2]), 32'h53);
    end

    // Glitch rejection, then a clean frame.
    clear_logs();
    hold(1'b0, 5);
    hold(1'b1, 40);
    chk("glitch_silent", 32'(valid_cyc.size() + ferr_cnt + perr_cnt), 32'd0);
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("after_glitch_count", 32'(valid_cyc.size()), 32'd1);
    chk("after_glitch_data", 32'(bus_if.data_out), 32'hA5);

    // Framing error keeps the previous byte.
    clear_logs();
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b1, 20);
    chk("ferr_count", 32'(ferr_cnt), 32'd1);
    chk("ferr_no_valid", 32'(valid_cyc.size()), 32'd0);
    chk("ferr_data_held", 32'(bus_if.data_out), 32'hA5);

    // Break: long low produces exactly one framing error.
    clear_logs();
    ev.cyc = cyc + 1 + LAT;
    ev.kind = K_FERR;
    ev.data = 8'h00;
    q.push_back(ev);
    hold(1'b0, 1000);
    hold(1'b1, 20);
    chk("break_ferr_count", 32'(ferr_cnt), 32'd1);
    chk("break_no_valid", 32'(valid_cyc.size()), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF.
    hold(1'b0, C);
    for (int i = 0; i < 4; i++) hold(1'b1, C);
    bus_if.rx_in = 1'b1;
    repeat (8) @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    model_data = 8'h00;
    q.delete();
    #1;
    chk("async_rst_data", 32'(bus_if.data_out), 32'h0);
    chk("async_rst_pulses", 32'({bus_if.valid_out, bus_if.framing_err_out, bus_if.parity_err_out}), 32'h0);
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    hold(1'b1, 10);
    clear_logs();
    send_frame(8'h01, 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("post_rst_count", 32'(valid_cyc.size()), 32'd1);
    chk("post_rst_data", 32'(bus_if.data_out), 32'h01);

`ifdef UART_RX_PARITY_EN
    clear_logs();
    send_frame(8'h53, 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("par_ok_count", 32'(valid_cyc.size()), 32'd1);
    chk("par_ok_data", 32'(bus_if.data_out), 32'h53);
    clear_logs();
    send_frame(8'h53, 1'b1, 1'b1);
    hold(1'b1, 20);
    chk("par_bad_perr", 32'(perr_cnt), 32'd1);
    chk("par_bad_no_valid", 32'(valid_cyc.size()), 32'd0);
`endif

    chk("model_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-oriented UART receiver that sits directly upstream of the host-to-FPGA RAM bridge command decoder. It synchronises the asynchronous serial line and recovers 8N1 frames by mid-bit sampling. Each received byte is delivered as a one-cycle `valid_out` pulse with `data_out`, which connects straight to the decoder's `data_in`/`valid_in`. Malformed frames are flagged and dropped, never forwarded.

## Interface
- `CLKS_PER_BAUD`, default 868: clock cycles per bit period (100 MHz / 115200). Legal range is 4 or more. It must be even; odd values are truncated in the half-bit computation.
- `clk_in`  input  1  system clock; all state updates on its rising edge.
- `rst_n_in`  input  1  reset; asynchronous, active-low.
- `rx_in`  input  1  raw serial line, asynchronous to `clk_in`, idles high.
- `data_out`  output  8  last successfully received byte; holds between frames.
- `valid_out`  output  1  one-cycle pulse; `data_out` is new on this cycle.
- `framing_err_out`  output  1  one-cycle pulse: stop bit sampled low.
- `parity_err_out`  output  1  one-cycle pulse: parity mismatch. Tied 0 unless the parity macro is defined.

## Operation
- `rx_in` passes through a 2-flop synchroniser. Both flops reset to 1. `rx_s` is the second flop's output; `rx_prev` is `rx_s` delayed by one cycle.
- Bit counter width is `$clog2(CLKS_PER_BAUD)`. Bit index is 3 bits.
- **IDLE**
  - Counter is 0.
  - Go to START on a falling edge: `rx_prev`=1 and `rx_s`=0.
  - A line held low (break) therefore never re-triggers.
- **START**
  - Counter increments each cycle. When counter = `CLKS_PER_BAUD/2 - 1`, sample `rx_s`.
  - Sample 0: go to DATA, clear counter and bit index.
  - Sample 1: glitch; return to IDLE with no output.
- **DATA**
  - When counter = `CLKS_PER_BAUD-1`, sample `rx_s` into the shift register LSB-first. Clear the counter and increment the bit index.
  - After bit index 7 is sampled, go to STOP (PARITY when parity is enabled).
- **STOP**
  - When counter = `CLKS_PER_BAUD-1`, sample `rx_s` and return to IDLE.
  - Sample 1 (and no parity error): next cycle `valid_out`=1 and `data_out`=shift register.
  - Sample 0: next cycle `framing_err_out`=1. `data_out` is unchanged and `valid_out` stays 0.
  - The error outputs are mutually exclusive with `valid_out`. Framing error takes precedence over parity error.
- Returning to IDLE at mid-stop-bit makes back-to-back frames with zero idle time receivable.
- **Reset mid-frame:** state goes to IDLE and all outputs read 0 immediately (asynchronous). The partial byte is discarded. The first falling edge after release starts a clean frame.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, `framing_err_out`=0, `parity_err_out`=0. State is IDLE and synchroniser flops are 1.
- All outputs are registered.
- **Latency:** `valid_out` asserts exactly `2 + CLKS_PER_BAUD/2 + 9*CLKS_PER_BAUD + 1` cycles after the first rising edge at which sync flop 1 captures `rx_in`=0. Add `CLKS_PER_BAUD` when parity is enabled.
- No backpressure. The consumer must accept every `valid_out` pulse; there is no buffering.
- Each pulse output is high for exactly 1 cycle per frame.
- Throughput: one byte per 10 bit periods (11 with parity).
- Baud tolerance: ±4% total mismatch is recovered correctly.

## Configuration
- `UART_RX_PARITY_EN`
  - **Defined:** frames are 8E1. After DATA, a PARITY state samples one bit at counter = `CLKS_PER_BAUD-1`, then goes to STOP. If the XOR of the 8 data bits and the parity bit is 1 and the stop bit is 1, `parity_err_out` pulses in place of `valid_out` and the byte is dropped.
  - **Undefined:** frames are 8N1, the PARITY state does not exist, and `parity_err_out` is constant 0.

## Test plan
All scenarios use `CLKS_PER_BAUD`=16.
- **Single byte:** send 0x57 (`"W"`), 8N1. Expect `valid_out` high for 1 cycle at exactly 155 cycles after capture (2 + 8 + 144 + 1), `data_out`=0x57. No error pulses.
- **Back-to-back:** send 0x52, 0x48, 0x53 with no idle bits. Expect three `valid_out` pulses 160 cycles apart carrying 0x52, 0x48, 0x53 in order.
- **Glitch rejection:** drive `rx_in` low for 5 cycles, then high. Expect no output. A following 0xA5 frame is received correctly.
- **Framing error and break:**
  - Send 0x3C with stop bit 0. Expect one `framing_err_out` pulse, no `valid_out`, and `data_out` holding its previous value.
  - Hold the line low 1000 cycles. Expect exactly one `framing_err_out` pulse.
- **Reset mid-frame:** assert `rst_n_in` low during data bit 4 of 0xFF. Expect all outputs 0 asynchronously. After release, 0x01 is received with `data_out`=0x01.
- **Parity (`UART_RX_PARITY_EN` defined):**
  - Send 0x53 with correct even parity. Expect `valid_out` and `data_out`=0x53.
  - Resend with the parity bit flipped. Expect `parity_err_out` pulse and no `valid_out`.
